poly_actor_enable_fsm: RTL and testbench
========================================

# poly_actor_enable_fsm

Parent enable/invoke controller for the polynomial-evaluation actor, directly upstream of `firing_state_FSM2`. It decides when the actor may fire and which firing to request, setup (command fetch) or instruction. It then pulses `start_fsm2` with the matching `next_instr` and tracks completion. Firing conditions are based on input command FIFO population and output result FIFO free space.

## Interface
- `word_size`, 16, width of FIFO population/free-space counts
- `setup_cycles`, 8, fixed wait after a setup firing (FSM2 gives no done for setup)
- `rst_cycles`, 4, fixed wait after an RST firing (FSM2 gives no done for RST)
- `timeout_cycles`, 4096, max cycles waiting for `done_fsm2` before fault
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `run`  in  1  scheduling enable; sampled only in IDLE
- `pop_in_fifo_command`  in  word_size  tokens in input command FIFO
- `free_out_result`  in  word_size  free slots in output result FIFO
- `instr`  in  8  decoded opcode from FSM2 (STP=0, EVP=1, EVB=2, RST=3)
- `arg2`  in  5  second argument; for EVB = batch count b
- `done_fsm2`  in  1  instruction firing complete
- `start_fsm2`  out  1  one-cycle firing request
- `next_instr`  out  2  SETUP_INSTR=2'b00, INSTR=2'b01
- `busy`  out  1  high in every state except IDLE and HALT
- `fire_count`  out  16  completed instruction firings, wraps at 2^16
- `bad_opcode`  out  1  sticky: instr outside 0..3 seen
- `timeout_err`  out  1  sticky: done_fsm2 timeout

## Operation
- States:
  - IDLE
  - SETUP_FIRE
  - SETUP_WAIT
  - INSTR_CHECK
  - INSTR_FIRE
  - INSTR_WAIT
  - RST_WAIT
  - HALT
- IDLE: `run` && `pop_in_fifo_command` >= 1 → SETUP_FIRE; else stay.
- SETUP_FIRE: `start_fsm2`=1, `next_instr`=00 → SETUP_WAIT. The wait counter loads 0.
- SETUP_WAIT: count to `setup_cycles`-1, then → INSTR_CHECK.
- INSTR_CHECK: evaluates every cycle until the condition is met.
  - STP or EVP: needs `free_out_result` >= 1.
  - EVB: needs `free_out_result` >= max(`arg2`,1).
  - RST: no condition.
  - When met → INSTR_FIRE; otherwise stay (backpressure stall).
  - Opcode >3: set `bad_opcode` and go to IDLE; the command is dropped.
- INSTR_FIRE: `start_fsm2`=1, `next_instr`=01. Latches whether the opcode is RST. RST → RST_WAIT; else → INSTR_WAIT. The wait counter loads 0.
- INSTR_WAIT:
  - `done_fsm2` → IDLE and `fire_count`+1.
  - Counter reaches `timeout_cycles`-1 without done → HALT and set `timeout_err`.
- RST_WAIT: count to `rst_cycles`-1 → IDLE; `fire_count`+1.
- HALT: terminal until `rst`. All strobes are 0.
- `run` low mid-firing does not abort; it takes effect at the next IDLE.
- `done_fsm2` outside INSTR_WAIT is ignored.

## Timing
- All outputs are registered. Reset values:
  - `start_fsm2`=0
  - `next_instr`=00
  - `busy`=0
  - `fire_count`=0
  - `bad_opcode`=0
  - `timeout_err`=0
  - state IDLE
- `start_fsm2` is high for exactly the one cycle the FSM is in SETUP_FIRE or INSTR_FIRE.
- `next_instr` is valid in that same cycle and holds until the next FIRE state. FSM2 samples it in its START state.
- Latency, run/pop condition to setup `start_fsm2`: 1 cycle.
- Setup pulse to earliest instruction pulse: `setup_cycles`+2 cycles.
- `done_fsm2` in INSTR_WAIT → IDLE next cycle, with `fire_count` updated that edge. The earliest next setup pulse follows 1 cycle later.
- The wait counter is 16 bits and saturates.
- Async reset mid-firing returns to IDLE immediately and clears the sticky flags.

## Structure
- Shared package `poly_pkg` holds:
  - opcode constants STP/EVP/EVB/RST
  - SETUP_INSTR/INSTR encodings
  - the state encoding
- These constants are shared with FSM2 and the get_command FSM.
- No sub-module; the wait/timeout counter is inline.

## Test plan
- Reset released, `run`=1, pop=0 → stays IDLE, `start_fsm2` never asserts; pop→1 → 1-cycle pulse with `next_instr`=00 one cycle later.
- STP, `free_out_result`=1, `done_fsm2` 5 cycles after instruction pulse → pulse with `next_instr`=01; IDLE; `fire_count`=1.
- EVB, `arg2`=6, free=5 → stalls in INSTR_CHECK, no pulse; free→6 → pulse on the next cycle.
- RST opcode, `rst_cycles`=4 → instruction pulse, `busy` for 4 more cycles, then IDLE, `fire_count`+1, with no `done_fsm2` driven.
- `instr`=7 after setup → `bad_opcode`=1, return to IDLE, no instruction pulse.
- EVP with no `done_fsm2`, `timeout_cycles`=16 → HALT after 16 cycles, `timeout_err`=1, `busy`=0. Async reset clears it.

Source files
------------

// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial-evaluation actor: opcodes, firing kinds
// and the enable-FSM state encoding, used by FSM2 and the get_command FSM too.
package poly_pkg;

   localparam logic [7:0] OP_STP = 8'd0;
   localparam logic [7:0] OP_EVP = 8'd1;
   localparam logic [7:0] OP_EVB = 8'd2;
   localparam logic [7:0] OP_RST = 8'd3;

   typedef enum logic [1:0] {
      SETUP_INSTR = 2'b00,
      INSTR       = 2'b01
   } fire_kind_e;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_SETUP_FIRE  = 3'd1,
      ST_SETUP_WAIT  = 3'd2,
      ST_INSTR_CHECK = 3'd3,
      ST_INSTR_FIRE  = 3'd4,
      ST_INSTR_WAIT  = 3'd5,
      ST_RST_WAIT    = 3'd6,
      ST_HALT        = 3'd7
   } state_e;

   function automatic logic opcode_valid(input logic [7:0] op);
      return op <= OP_RST;
   endfunction

   // A batch of zero still produces one result, so it needs one free slot.
   function automatic logic [4:0] evb_slots(input logic [4:0] batch);
      return (batch == 5'd0) ? 5'd1 : batch;
   endfunction

endpackage

// File: rtl/poly_actor_enable_fsm.sv
// Enable/invoke controller for the polynomial actor: decides when to fire
// FSM2 (setup or instruction), pulses start_fsm2 and tracks completion.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// ST_IDLE        | waiting for run and a queued command
// ST_SETUP_FIRE  | one-cycle setup (command fetch) request to FSM2
// ST_SETUP_WAIT  | fixed setup_cycles wait, FSM2 gives no done for setup
// ST_INSTR_CHECK | waiting for output space for the decoded opcode
// ST_INSTR_FIRE  | one-cycle instruction request to FSM2
// ST_INSTR_WAIT  | waiting for done_fsm2, bounded by timeout_cycles
// ST_RST_WAIT    | fixed rst_cycles wait after an RST firing
// ST_HALT        | timeout fault, parked until reset
module poly_actor_enable_fsm
   import poly_pkg::*;
#(
   parameter int WORD_SIZE      = 16,
   parameter int SETUP_CYCLES   = 8,
   parameter int RST_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic [WORD_SIZE-1:0] pop_in_fifo_command,
   input  logic [WORD_SIZE-1:0] free_out_result,
   input  logic [7:0]           instr,
   input  logic [4:0]           arg2,
   input  logic                 done_fsm2,
   output logic                 start_fsm2,
   output logic [1:0]           next_instr,
   output logic                 busy,
   output logic [15:0]          fire_count,
   output logic                 bad_opcode,
   output logic                 timeout_err
);

   localparam logic [15:0] SETUP_TC   = 16'(SETUP_CYCLES - 1);
   localparam logic [15:0] RST_TC     = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES - 1);

   state_e     state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_inc;
   logic        is_rst_q, is_rst_d;
   logic        start_q;
   fire_kind_e  next_instr_q;
   logic        busy_q;
   logic [15:0] fire_count_q;
   logic        bad_opcode_q;
   logic        timeout_err_q;

   logic        fire_done;
   logic        set_bad;
   logic        set_timeout;
   logic        space_ok;

   assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

   always_comb begin
      space_ok = 1'b0;
      case (instr)
         OP_STP, OP_EVP: space_ok = (free_out_result != '0);
         OP_EVB:         space_ok = (free_out_result >= WORD_SIZE'(evb_slots(arg2)));
         OP_RST:         space_ok = 1'b1;
         default:        space_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_rst_d    = is_rst_q;
      fire_done   = 1'b0;
      set_bad     = 1'b0;
      set_timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run && (pop_in_fifo_command != '0)) state_d = ST_SETUP_FIRE;
         end
         ST_SETUP_FIRE: begin
            state_d = ST_SETUP_WAIT;
            cnt_d   = 16'd0;
         end
         ST_SETUP_WAIT: begin
            if (cnt_q == SETUP_TC) state_d = ST_INSTR_CHECK;
            else                   cnt_d   = cnt_inc;
         end
         ST_INSTR_CHECK: begin
            if (!opcode_valid(instr)) begin
               // Unknown opcode: the command is dropped, not retried.
               set_bad = 1'b1;
               state_d = ST_IDLE;
            end else if (space_ok) begin
               state_d  = ST_INSTR_FIRE;
               is_rst_d = (instr == OP_RST);
            end
         end
         ST_INSTR_FIRE: begin
            state_d = is_rst_q ? ST_RST_WAIT : ST_INSTR_WAIT;
            cnt_d   = 16'd0;
         end
         ST_INSTR_WAIT: begin
            if (done_fsm2) begin
               state_d   = ST_IDLE;
               fire_done = 1'b1;
            end else if (cnt_q == TIMEOUT_TC) begin
               state_d     = ST_HALT;
               set_timeout = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RST_WAIT: begin
            if (cnt_q == RST_TC) begin
               state_d   = ST_IDLE;
               fire_done = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are derived from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 16'd0;
         is_rst_q      <= 1'b0;
         start_q       <= 1'b0;
         next_instr_q  <= SETUP_INSTR;
         busy_q        <= 1'b0;
         fire_count_q  <= 16'd0;
         bad_opcode_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_rst_q <= is_rst_d;
         start_q  <= (state_d == ST_SETUP_FIRE) || (state_d == ST_INSTR_FIRE);
         if (state_d == ST_SETUP_FIRE)      next_instr_q <= SETUP_INSTR;
         else if (state_d == ST_INSTR_FIRE) next_instr_q <= INSTR;
         busy_q        <= (state_d != ST_IDLE) && (state_d != ST_HALT);
         fire_count_q  <= fire_count_q + 16'(fire_done);
         bad_opcode_q  <= bad_opcode_q | set_bad;
         timeout_err_q <= timeout_err_q | set_timeout;
      end
   end

   assign start_fsm2  = start_q;
   assign next_instr  = next_instr_q;
   assign busy        = busy_q;
   assign fire_count  = fire_count_q;
   assign bad_opcode  = bad_opcode_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_poly_actor_enable_fsm.sv
// Bench for poly_actor_enable_fsm: directed and randomized commands checked
// against pulse timings derived from the firing rules.
module tb_poly_actor_enable_fsm;

   localparam int SETUP = 8;
   localparam int RSTC  = 4;
   localparam int TMO   = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [15:0] pop_in_fifo_command = '0;
   logic [15:0] free_out_result = '0;
   logic [7:0]  instr = '0;
   logic [4:0]  arg2 = '0;
   logic        done_fsm2 = 1'b0;
   logic        start_fsm2;
   logic [1:0]  next_instr;
   logic        busy;
   logic [15:0] fire_count;
   logic        bad_opcode;
   logic        timeout_err;

   int checks_total  = 0;
   int checks_passed = 0;
   int cyc = 0;
   int exp_fc = 0;
   int p_t[$];
   int p_ni[$];

   poly_actor_enable_fsm #(
      .WORD_SIZE(16), .SETUP_CYCLES(SETUP), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst), .run(run),
      .pop_in_fifo_command(pop_in_fifo_command), .free_out_result(free_out_result),
      .instr(instr), .arg2(arg2), .done_fsm2(done_fsm2),
      .start_fsm2(start_fsm2), .next_instr(next_instr), .busy(busy),
      .fire_count(fire_count), .bad_opcode(bad_opcode), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Log every start pulse with the cycle number it was seen in.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (start_fsm2 === 1'b1) begin
         p_t.push_back(cyc);
         p_ni.push_back(int'(next_instr));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic goto(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   function automatic bit model_met(input int op, input int a2, input int fr);
      if (op <= 1) return fr >= 1;
      if (op == 2) return fr >= ((a2 == 0) ? 1 : a2);
      return 1'b1;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      #2 rst = 1'b0;
      run = 1'b0; pop_in_fifo_command = '0; done_fsm2 = 1'b0;
      free_out_result = '0; instr = '0; arg2 = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_fc = 0;
   endtask

   // One full command: setup pulse, optional stall, instruction pulse, completion.
   task automatic do_cmd(input int op, input int a2, input int fr, input int stall,
                         input int raise, input int dly, input bit hold);
      int c0, e;
      bit met;
      p_t.delete(); p_ni.delete();
      instr = 8'(op); arg2 = 5'(a2); free_out_result = 16'(fr);
      pop_in_fifo_command = 16'd1; run = 1'b1; done_fsm2 = 1'b0;
      c0 = cyc;
      goto(c0 + 1);
      if (!hold) run = 1'b0;
      check("setup_pulse_count", p_t.size(), 1);
      if (p_t.size() >= 1) begin
         check("setup_pulse_time", p_t[0], c0 + 1);
         check("setup_next_instr", p_ni[0], 0);
      end
      if (op > 3) begin
         goto(c0 + SETUP + 3);
         check("bad_no_instr_pulse", p_t.size(), 1);
         check("bad_opcode_set", bad_opcode, 1);
         check("bad_busy_low", busy, 0);
         check("bad_fire_count", fire_count, exp_fc);
         apply_reset();
         return;
      end
      met = model_met(op, a2, fr);
      if (!met) begin
         goto(c0 + SETUP + 2 + stall);
         check("stall_no_pulse", p_t.size(), 1);
         check("stall_busy", busy, 1);
         free_out_result = 16'(raise);
      end
      e = c0 + SETUP + 3 + (met ? 0 : stall);
      goto(e);
      check("instr_pulse_count", p_t.size(), 2);
      if (p_t.size() >= 2) begin
         check("instr_pulse_time", p_t[1], e);
         check("instr_next_instr", p_ni[1], 1);
      end
      if (op == 3) begin
         goto(e + RSTC);
         check("rst_wait_busy", busy, 1);
         goto(e + RSTC + 1);
         exp_fc++;
         check("rst_done_busy", busy, 0);
         check("rst_fire_count", fire_count, 16'(exp_fc));
      end else begin
         goto(e + dly);
         done_fsm2 = 1'b1;
         goto(e + dly + 1);
         exp_fc++;
         check("done_busy", busy, 0);
         check("done_fire_count", fire_count, 16'(exp_fc));
         check("next_instr_held", next_instr, 1);
         done_fsm2 = 1'b0;
         if (hold) begin
            goto(e + dly + 2);
            check("b2b_pulse_count", p_t.size(), 3);
            if (p_t.size() >= 3) check("b2b_pulse_time", p_t[2], e + dly + 2);
            run = 1'b0;
            apply_reset();
         end
      end
   endtask

   initial begin
      int c0, e;
      #2 rst = 1'b0;
      #1;
      check("rst_start", start_fsm2, 0);
      check("rst_next_instr", next_instr, 0);
      check("rst_busy", busy, 0);
      check("rst_fire_count", fire_count, 0);
      check("rst_bad_opcode", bad_opcode, 0);
      check("rst_timeout", timeout_err, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      run = 1'b1; pop_in_fifo_command = '0;
      repeat (10) @(negedge clk);
      check("no_pop_no_pulse", p_t.size(), 0);
      run = 1'b0; pop_in_fifo_command = 16'd3;
      repeat (10) @(negedge clk);
      check("no_run_no_pulse", p_t.size(), 0);

      do_cmd(0, 0, 1, 0, 0, 5, 0);
      do_cmd(2, 6, 5, 3, 6, 3, 0);
      do_cmd(2, 0, 1, 0, 0, 4, 0);
      do_cmd(3, 0, 0, 0, 0, 0, 0);
      do_cmd(1, 0, 2, 0, 0, 2, 1);
      do_cmd(7, 0, 9, 0, 0, 0, 0);

      // done_fsm2 while idle must not count a firing.
      exp_fc = int'(fire_count);
      run = 1'b0; done_fsm2 = 1'b1;
      repeat (3) @(negedge clk);
      done_fsm2 = 1'b0;
      check("done_ignored_idle", fire_count, 16'(exp_fc));

      // Async reset during the setup wait.
      p_t.delete(); p_ni.delete();
      instr = 8'd1; free_out_result = 16'd4; pop_in_fifo_command = 16'd1; run = 1'b1;
      c0 = cyc;
      goto(c0 + 4);
      run = 1'b0;
      check("midfire_busy", busy, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_fire_count", fire_count, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_fc = 0;

      // Timeout: EVP with no done_fsm2.
      p_t.delete(); p_ni.delete();
      instr = 8'd1; free_out_result = 16'd1; pop_in_fifo_command = 16'd1; run = 1'b1;
      c0 = cyc;
      goto(c0 + 1);
      run = 1'b0;
      e = c0 + SETUP + 3;
      goto(e);
      check("tmo_instr_pulses", p_t.size(), 2);
      goto(e + TMO);
      check("tmo_busy_before", busy, 1);
      check("tmo_flag_before", timeout_err, 0);
      goto(e + TMO + 1);
      check("tmo_busy_halt", busy, 0);
      check("tmo_flag_set", timeout_err, 1);
      run = 1'b1;
      goto(e + TMO + 8);
      check("halt_no_pulse", p_t.size(), 2);
      check("halt_fire_count", fire_count, 0);
      run = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("tmo_cleared", timeout_err, 0);
      @(negedge clk);
      rst = 1'b1;
      exp_fc = 0;

      for (int i = 0; i < 20; i++) begin
         int op, a2, fr;
         op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 255));
         a2 = int'($urandom_range(0, 31));
         fr = int'($urandom_range(0, 31));
         do_cmd(op, a2, fr, int'($urandom_range(1, 4)), 31, int'($urandom_range(1, 12)),
                1'b0);
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
